// File: rtl/imm_narrow_unit.sv
// imm_narrow_unit
// Narrows an M-bit immediate to N bits through a two-stage valid/ready
// pipeline and reports whether the narrowed value represents the input
// exactly, under either unsigned (U=1) or signed (U=0) interpretation.
//
// Build option: IMM_NARROW_SAT_EN
//   defined   -> out-of-range words saturate to the nearest representable value
//   undefined -> out-of-range words are truncated to immediateIN[N-1:0]
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   U             1 = unsigned range check, 0 = signed range check
//   immediateIN   wide input value (M bits)
//   in_valid      input word valid
//   in_ready      block accepts a word this cycle
//   immediateOUT  narrowed value (N bits)
//   out_fits      1 = immediateOUT exactly represents the input
//   out_valid     immediateOUT/out_fits valid
//   out_ready     consumer accepts output
//   clr_count     synchronous clear of ovf_count
//   ovf_count     saturating count of accepted words that did not fit
module imm_narrow_unit #(
   parameter int N = 16,
   parameter int M = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         U,
   input  logic [M-1:0] immediateIN,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] immediateOUT,
   output logic         out_fits,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic         clr_count,
   output logic [15:0]  ovf_count
);

   // S1 keeps only what S2 needs: the low bits, the sign bit and the mode.
   logic         s1_valid;
   logic [N-1:0] s1_lo;
   logic         s1_msb;
   logic         s1_u;
   logic         s1_fit;

   logic         fit_in;
   logic         s2_adv;
   logic         s1_adv;
   logic         in_fire;
   logic [N-1:0] narrow_val;

   always_comb begin
      fit_in = 1'b0;
      if (U)
         fit_in = ~|immediateIN[M-1:N];
      else
         fit_in = (&immediateIN[M-1:N-1]) | (~|immediateIN[M-1:N-1]);
   end

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_adv;
   // Held low during reset so nothing is accepted while the pipe is cleared.
   assign in_ready = !rst && (!s1_valid || s1_adv);
   assign in_fire  = in_valid && in_ready;

`ifdef IMM_NARROW_SAT_EN
   always_comb begin
      narrow_val = s1_lo;
      if (!s1_fit) begin
         if (s1_u)
            narrow_val = {N{1'b1}};
         else if (!s1_msb)
            narrow_val = {1'b0, {(N-1){1'b1}}};
         else
            narrow_val = {1'b1, {(N-1){1'b0}}};
      end
   end
`else
   assign narrow_val = s1_lo;
   logic unused_sat_inputs;
   assign unused_sat_inputs = ^{s1_msb, s1_u};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         s1_lo        <= '0;
         s1_msb       <= 1'b0;
         s1_u         <= 1'b0;
         s1_fit       <= 1'b0;
         out_valid    <= 1'b0;
         immediateOUT <= '0;
         out_fits     <= 1'b0;
         ovf_count    <= '0;
      end else begin
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               immediateOUT <= narrow_val;
               out_fits     <= s1_fit;
            end
         end

         // in_ready already means S1 is empty or draining this cycle.
         if (in_ready)
            s1_valid <= in_valid;
         if (in_fire) begin
            s1_lo  <= immediateIN[N-1:0];
            s1_msb <= immediateIN[M-1];
            s1_u   <= U;
            s1_fit <= fit_in;
         end

         if (clr_count)
            ovf_count <= '0;
         else if (in_fire && !fit_in && (ovf_count != 16'hFFFF))
            ovf_count <= ovf_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_imm_narrow_unit.sv
// tb_imm_narrow_unit
// Directed bench for imm_narrow_unit at N=16, M=32. Expected values are
// hand-computed; the saturation build (IMM_NARROW_SAT_EN) selects the
// alternate expected outputs for out-of-range words.
module tb_imm_narrow_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        U;
   logic [31:0] immediateIN;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] immediateOUT;
   logic        out_fits;
   logic        out_valid;
   logic        out_ready;
   logic        clr_count;
   logic [15:0] ovf_count;

   int n_run  = 0;
   int n_fail = 0;

   imm_narrow_unit #(.N(16), .M(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .U            (U),
      .immediateIN  (immediateIN),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .immediateOUT (immediateOUT),
      .out_fits     (out_fits),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .clr_count    (clr_count),
      .ovf_count    (ovf_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one word into an empty pipe with out_ready=1, check it two edges later.
   task automatic one_word(input string tag, input logic u, input logic [31:0] d,
                           input logic [15:0] exp_out, input logic exp_fit,
                           input logic [15:0] exp_ovf);
      U = u; immediateIN = d; in_valid = 1'b1;
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      tick();
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_out"},   {16'd0, immediateOUT}, {16'd0, exp_out});
      chk({tag, "_fits"},  {31'd0, out_fits}, {31'd0, exp_fit});
      chk({tag, "_ovf"},   {16'd0, ovf_count}, {16'd0, exp_ovf});
      tick();
      chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; U = 1'b0; immediateIN = '0; in_valid = 1'b0;
      out_ready = 1'b1; clr_count = 1'b0;
      #1;
      tick(); tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("rst_ovf",       {16'd0, ovf_count}, 32'd0);
      chk("rst_out",       {16'd0, immediateOUT}, 32'd0);
      chk("rst_fits",      {31'd0, out_fits}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready",  {31'd0, in_ready}, 32'd1);

      one_word("s_neg_fit", 1'b0, 32'hFFFF_8000, 16'h8000, 1'b1, 16'd0);
`ifdef IMM_NARROW_SAT_EN
      one_word("s_pos_ovf", 1'b0, 32'h0000_8000, 16'h7FFF, 1'b0, 16'd1);
      one_word("u_ovf",     1'b1, 32'h0001_0000, 16'hFFFF, 1'b0, 16'd2);
      one_word("s_neg_ovf", 1'b0, 32'h8000_0000, 16'h8000, 1'b0, 16'd3);
`else
      one_word("s_pos_ovf", 1'b0, 32'h0000_8000, 16'h8000, 1'b0, 16'd1);
      one_word("u_ovf",     1'b1, 32'h0001_0000, 16'h0000, 1'b0, 16'd2);
      one_word("s_neg_ovf", 1'b0, 32'h8000_0000, 16'h0000, 1'b0, 16'd3);
`endif
      one_word("u_max_fit", 1'b1, 32'h0000_FFFF, 16'hFFFF, 1'b1, 16'd3);
      one_word("s_pos_fit", 1'b0, 32'h0000_7FFF, 16'h7FFF, 1'b1, 16'd3);

      // Backpressure: three back-to-back words, only two held.
      out_ready = 1'b0; U = 1'b1;
      immediateIN = 32'h11; in_valid = 1'b1;
      tick();
      chk("bp_rdy_b", {31'd0, in_ready}, 32'd1);
      immediateIN = 32'h22;
      tick();
      immediateIN = 32'h33;
      chk("bp_rdy_c",   {31'd0, in_ready}, 32'd0);
      chk("bp_valid_a", {31'd0, out_valid}, 32'd1);
      chk("bp_out_a",   {16'd0, immediateOUT}, 32'h11);
      tick();
      chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_a",   {16'd0, immediateOUT}, 32'h11);
      out_ready = 1'b1;
      #1;
      chk("bp_rdy_rel", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_valid_b", {31'd0, out_valid}, 32'd1);
      chk("bp_out_b",   {16'd0, immediateOUT}, 32'h22);
      tick();
      chk("bp_valid_c", {31'd0, out_valid}, 32'd1);
      chk("bp_out_c",   {16'd0, immediateOUT}, 32'h33);
      tick();
      chk("bp_empty",   {31'd0, out_valid}, 32'd0);

      // Reset with both stages full.
      out_ready = 1'b0; U = 1'b1;
      immediateIN = 32'h44; in_valid = 1'b1;
      tick();
      immediateIN = 32'h55;
      tick();
      in_valid = 1'b0;
      chk("rf_full", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      tick();
      chk("rf_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rf_ovf",       {16'd0, ovf_count}, 32'd0);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      chk("rf_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rf_no_stale", {31'd0, out_valid}, 32'd0);
      end

      // Counter saturation and clear priority.
      U = 1'b1; immediateIN = 32'h0001_0000; in_valid = 1'b1;
      repeat (65535) tick();
      chk("sat_reach", {16'd0, ovf_count}, 32'hFFFF);
      chk("thru_rdy",  {31'd0, in_ready}, 32'd1);
      chk("thru_vld",  {31'd0, out_valid}, 32'd1);
      tick();
      chk("sat_hold",  {16'd0, ovf_count}, 32'hFFFF);
      clr_count = 1'b1;
      tick();
      chk("clr_wins",  {16'd0, ovf_count}, 32'd0);
      clr_count = 1'b0;
      tick();
      chk("after_clr", {16'd0, ovf_count}, 32'd1);
      in_valid = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
